// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Segment patterns are active-high, bit 6 = segment A through bit 0 = segment G.
package seven_seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Indexed by nibble value: 0-9, A, b, C, d, E, F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110,
        7'b0110000,
        7'b1101101,
        7'b1111001,
        7'b0110011,
        7'b1011011,
        7'b1011111,
        7'b1110000,
        7'b1111111,
        7'b1111011,
        7'b1110111,
        7'b0011111,
        7'b1001110,
        7'b0111101,
        7'b1001111,
        7'b1000111
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Purely combinational hex nibble to seven-segment pattern lookup.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed four-digit seven-segment scanner with a one-deep, frame-aligned
// update buffer so the displayed value only ever changes between frames.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_BLANK | all anodes off for BLANK_CYCLES before driving digit idx
//   ST_DRIVE | digit idx lit for DIGIT_CYCLES; idx advances on the last cycle
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic        wr_ready,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CNT_MAX = max_int(DIGIT_CYCLES, BLANK_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reset leaves one extra count so the first blank period begins at the
    // first clock edge after release rather than during reset.
    localparam logic [CNT_W-1:0] BLANK_INIT = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);

    scan_state_t      state;
    scan_state_t      state_n;
    logic [1:0]       idx;
    logic [1:0]       idx_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             cnt_tc;

    logic [15:0]      act_data;
    logic [15:0]      act_data_n;
    logic [3:0]       act_dp;
    logic [3:0]       act_dp_n;
    logic [15:0]      pend_data;
    logic [3:0]       pend_dp;
    logic             accept;
    logic             copy;

    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic [6:0]       seg_n;
    logic             dp_n;
    logic [3:0]       an_n;
    logic             frame_done_n;

    assign cnt_tc       = (cnt == '0);
    assign accept       = wr_valid && wr_ready;
    // wr_ready low means a value is waiting; a capture in the frame_done
    // cycle itself still sees wr_ready high and waits a full frame.
    assign copy         = frame_done && !wr_ready;
    assign act_data_n   = copy ? pend_data : act_data;
    assign act_dp_n     = copy ? pend_dp : act_dp;
    assign frame_done_n = (state == ST_DRIVE) && (idx == 2'd3) && cnt_tc;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt - 1'b1;
        case (state)
            ST_BLANK: begin
                if (cnt_tc) begin
                    state_n = ST_DRIVE;
                    cnt_n   = DIGIT_LOAD;
                end
            end
            ST_DRIVE: begin
                if (cnt_tc) begin
                    state_n = ST_BLANK;
                    cnt_n   = BLANK_LOAD;
                    idx_n   = idx + 2'd1;
                end
            end
            default: begin
                state_n = ST_BLANK;
                cnt_n   = BLANK_LOAD;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with
    // the state register in the same cycle.
    assign nibble = act_data_n[{idx_n, 2'b00} +: 4];

    seven_seg_decode u_decode (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        an_n  = 4'b1111;
        seg_n = SEG_BLANK;
        dp_n  = 1'b0;
        if (state_n == ST_DRIVE) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = seg_dec;
            dp_n  = act_dp_n[idx_n];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_BLANK;
            idx   <= 2'd0;
            cnt   <= BLANK_INIT;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_n;
            seg        <= seg_n;
            dp         <= dp_n;
            frame_done <= frame_done_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_data  <= 16'h0000;
            act_dp    <= 4'b0000;
            pend_data <= 16'h0000;
            pend_dp   <= 4'b0000;
            wr_ready  <= 1'b1;
        end else begin
            act_data <= act_data_n;
            act_dp   <= act_dp_n;
            if (accept) begin
                pend_data <= wr_data;
                pend_dp   <= wr_dp;
            end
            if (copy) begin
                wr_ready <= 1'b1;
            end else if (accept) begin
                wr_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: expected digit periods and write
// acceptance cycles are queued by the stimulus and consumed by a monitor.
module tb_seven_seg_scan_ctrl;

    localparam int DIGIT_CYCLES = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME_CYCLES = 4 * (DIGIT_CYCLES + BLANK_CYCLES);

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic        wr_ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    rec_t exp_q[$];
    int   acc_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fd_count = 0;
    int   cyc;

    seven_seg_scan_ctrl #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_ready   (wr_ready),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc = k after the k-th rising edge since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input int ndig);
        rec_t       r;
        logic [3:0] one_hot;
        for (int i = 0; i < ndig; i++) begin
            one_hot = 4'b0001 << i;
            r.an    = ~one_hot;
            r.seg   = SEG_TAB[d[i*4 +: 4]];
            r.dp    = p[i];
            exp_q.push_back(r);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Stimulus
    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        wr_dp    = 4'b0000;

        push_frame(16'h0000, 4'b0000, 4);
        push_frame(16'hA810, 4'b0100, 4);
        push_frame(16'h1357, 4'b0001, 4);
        push_frame(16'h2468, 4'b0010, 4);
        push_frame(16'h9BDF, 4'b1000, 4);
        push_frame(16'h9BDF, 4'b1000, 4);
        push_frame(16'h9BDF, 4'b1000, 4);
        push_frame(16'hFFFF, 4'b1111, 4);
        push_frame(16'hFFFF, 4'b1111, 2);
        acc_q.push_back(11);
        acc_q.push_back(30);
        acc_q.push_back(51);
        acc_q.push_back(75);
        acc_q.push_back(99);
        acc_q.push_back(146);
        acc_q.push_back(196);

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // single mid-frame write
        wait_cyc(10);
        wr_valid = 1'b1; wr_data = 16'hA810; wr_dp = 4'b0100;
        wait_cyc(11);
        wr_valid = 1'b0; wr_data = 16'h0000; wr_dp = 4'b0000;

        // wr_valid held high across several frames, data changed while stalled
        wait_cyc(29);
        wr_valid = 1'b1; wr_data = 16'h1357; wr_dp = 4'b0001;
        wait_cyc(40);
        wr_data = 16'h2468; wr_dp = 4'b0010;
        wait_cyc(60);
        wr_data = 16'h9BDF; wr_dp = 4'b1000;
        wait_cyc(100);
        wr_valid = 1'b0;

        // capture coincident with frame_done
        wait_cyc(145);
        wr_valid = 1'b1; wr_data = 16'hFFFF; wr_dp = 4'b1111;
        wait_cyc(146);
        wr_valid = 1'b0;

        // pending value then reset during DRIVE of digit 2
        wait_cyc(195);
        wr_valid = 1'b1; wr_data = 16'h1234; wr_dp = 4'b0101;
        wait_cyc(196);
        wr_valid = 1'b0;
        wait_cyc(208);
        rst = 1'b0;
        push_frame(16'h0000, 4'b0000, 4);
        push_frame(16'h0000, 4'b0000, 4);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        wait_cyc(52);

        check("frame_done_count", 32'(fd_count), 32'(10));
        check("digit_queue_left", 32'(exp_q.size()), 32'(0));
        check("accept_queue_left", 32'(acc_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Asynchronous reset must take effect with no clock edge
    initial begin
        forever begin
            @(negedge rst);
            #1;
            check("async_reset_outputs", 32'({an, seg, dp, frame_done, wr_ready}),
                  32'({4'b1111, 7'b0000000, 1'b0, 1'b0, 1'b1}));
        end
    end

    // Monitor
    initial begin
        logic       run_valid;
        logic       run_blank;
        logic       run_stable;
        logic       just_ended;
        logic       ready_chk;
        logic       blank;
        logic       legal;
        logic [3:0] run_an;
        logic [3:0] last_end_an;
        logic [6:0] run_seg;
        logic       run_dp;
        int         run_len;
        int         last_fd;
        rec_t       e;

        run_valid   = 1'b0;
        run_blank   = 1'b0;
        run_stable  = 1'b1;
        ready_chk   = 1'b0;
        run_an      = 4'b1111;
        last_end_an = 4'b1111;
        run_seg     = 7'b0;
        run_dp      = 1'b0;
        run_len     = 0;
        last_fd     = 1;
        forever begin
            @(negedge clk);
            if (!rst || cyc == 0) begin
                run_valid   = 1'b0;
                ready_chk   = 1'b0;
                last_fd     = 1;
                last_end_an = 4'b1111;
                if (!rst)
                    check("reset_outputs", 32'({an, seg, dp, frame_done, wr_ready}),
                          32'({4'b1111, 7'b0000000, 1'b0, 1'b0, 1'b1}));
            end else begin
                blank = (an == 4'b1111);
                legal = blank || an == 4'b1110 || an == 4'b1101 || an == 4'b1011 || an == 4'b0111;
                check("an_one_hot_low", 32'(legal), 32'(1));
                if (blank) check("blank_seg_dp", 32'({seg, dp}), 32'(0));

                if (ready_chk) begin
                    check("ready_low_after_accept", 32'(wr_ready), 32'(0));
                    ready_chk = 1'b0;
                end
                if (wr_valid && wr_ready) begin
                    if (acc_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL accept_unexpected: acceptance at edge %0d, none expected", cyc + 1);
                    end else begin
                        check("accept_cycle", 32'(cyc + 1), 32'(acc_q.pop_front()));
                    end
                    ready_chk = 1'b1;
                end

                just_ended = 1'b0;
                if (run_valid && (blank != run_blank || an != run_an)) begin
                    if (run_blank) begin
                        check("blank_len", 32'(run_len), 32'(BLANK_CYCLES));
                    end else begin
                        check("drive_len", 32'(run_len), 32'(DIGIT_CYCLES));
                        check("drive_stable", 32'(run_stable), 32'(1));
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL digit_unexpected: an=%b seg=%b, none expected", run_an, run_seg);
                        end else begin
                            e = exp_q.pop_front();
                            check("digit_an", 32'(run_an), 32'(e.an));
                            check("digit_seg", 32'(run_seg), 32'(e.seg));
                            check("digit_dp", 32'(run_dp), 32'(e.dp));
                        end
                    end
                    last_end_an = run_an;
                    just_ended  = 1'b1;
                    run_valid   = 1'b0;
                end

                if (frame_done) begin
                    check("frame_done_spacing", 32'(cyc - last_fd), 32'(FRAME_CYCLES));
                    check("frame_done_position", 32'({just_ended, blank, last_end_an}),
                          32'({1'b1, 1'b1, 4'b0111}));
                    last_fd = cyc;
                    fd_count++;
                end

                if (!run_valid) begin
                    run_valid  = 1'b1;
                    run_blank  = blank;
                    run_an     = an;
                    run_seg    = seg;
                    run_dp     = dp;
                    run_len    = 1;
                    run_stable = 1'b1;
                end else begin
                    run_len++;
                    if (seg !== run_seg || dp !== run_dp) run_stable = 1'b0;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
